// File: rtl/game_pkg.sv
// Shared types and constants for the digit entry path of the number game.
package game_pkg;
  localparam int NUM_SLOTS  = 4;
  localparam int MAX_DIGITS = 3;
  localparam int VAL_W      = 10;
  localparam int BCD_W      = 12;

  typedef enum logic [1:0] {ENTRY, CONVERT, COMPLETE} state_t;

  // One cycle of button activity; the FSM resolves priority among these.
  typedef struct packed {
    logic       enter;
    logic       backspace;
    logic       dvalid;
    logic [3:0] digit;
  } entry_req_t;

  // acc*10 + d, built from shifts so no multiplier is needed.
  function automatic logic [VAL_W-1:0] mul10_add(input logic [VAL_W-1:0] acc,
                                                 input logic [3:0]       d);
    return (acc << 3) + (acc << 1) + VAL_W'(d);
  endfunction
endpackage

// File: rtl/bcd_serial_to_bin.sv
// Serial BCD-to-binary: one digit per cycle, most significant first.
// result/done are combinational on the final stage so the caller can
// commit on the third edge after start.
module bcd_serial_to_bin
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd,
  output logic [VAL_W-1:0] result,
  output logic             done
);
  localparam int STAGES = MAX_DIGITS - 1;

  logic [STAGES:0]  vld_pipe;
  logic [VAL_W-1:0] acc;
  logic [3:0]       dsel;

  // Stage i consumes digit index STAGES-i.
  always_comb begin
    dsel = '0;
    for (int i = 0; i <= STAGES; i++)
      if (vld_pipe[i]) dsel = bcd[(STAGES-i)*4 +: 4];
  end

  assign result = mul10_add(acc, dsel);
  assign done   = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_pipe <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], start};
      if (start)         acc <= '0;
      else if (|vld_pipe) acc <= result;
    end
  end
endmodule

// File: rtl/digit_entry_encoder.sv
// Button digit entry: collects up to three BCD digits, converts them to binary
// on enter and stores the result into the next of four number slots.
module digit_entry_encoder
  import game_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       digit_valid,
  input  logic [3:0]                 digit,
  input  logic                       backspace,
  input  logic                       enter,
  output logic [NUM_SLOTS*VAL_W-1:0] nums,
  output logic [NUM_SLOTS-1:0]       valid,
  output logic [BCD_W-1:0]           cur_bcd,
  output logic [1:0]                 cur_count,
  output logic [1:0]                 cur_slot,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  state_t                              state;
  entry_req_t                          req;
  logic [NUM_SLOTS-1:0][VAL_W-1:0]     slots;
  logic                                conv_start;
  logic                                conv_done;
  logic [VAL_W-1:0]                    conv_result;

  assign req   = '{enter: enter, backspace: backspace, dvalid: digit_valid, digit: digit};
  assign nums  = slots;

  assign conv_start = (state == ENTRY) && req.enter && (cur_count != 2'd0) && !clear;

  bcd_serial_to_bin u_conv (
    .clk    (clk),
    .rst    (rst),
    .flush  (clear),
    .start  (conv_start),
    .bcd    (cur_bcd),
    .result (conv_result),
    .done   (conv_done)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ENTRY;
      slots     <= '0;
      valid     <= '0;
      cur_bcd   <= '0;
      cur_count <= '0;
      cur_slot  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ENTRY: begin
          if (req.enter) begin
            if (cur_count == 2'd0) begin
              err <= 1'b1;
            end else begin
              state <= CONVERT;
              busy  <= 1'b1;
            end
          end else if (req.backspace) begin
            if (cur_count != 2'd0) begin
              cur_bcd   <= {4'h0, cur_bcd[BCD_W-1:4]};
              cur_count <= cur_count - 2'd1;
            end
          end else if (req.dvalid) begin
            if (req.digit > 4'd9 || cur_count == 2'(MAX_DIGITS)) begin
              err <= 1'b1;
            end else begin
              cur_bcd   <= {cur_bcd[BCD_W-5:0], req.digit};
              cur_count <= cur_count + 2'd1;
            end
          end
        end
        CONVERT: begin
          // Buttons are ignored here; the digits must stay put for the converter.
          if (conv_done) begin
            slots[cur_slot] <= conv_result;
            valid[cur_slot] <= 1'b1;
            cur_bcd         <= '0;
            cur_count       <= '0;
            busy            <= 1'b0;
            if (cur_slot == 2'(NUM_SLOTS-1)) begin
              state <= COMPLETE;
              done  <= 1'b1;
            end else begin
              cur_slot <= cur_slot + 2'd1;
              state    <= ENTRY;
            end
          end
        end
        COMPLETE: begin
          if (req.dvalid || req.enter) err <= 1'b1;
        end
        default: state <= ENTRY;
      endcase
    end
  end
endmodule
